// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES-128 inverse cipher (FIPS-197 InvCipher).
// One round per clock. On-chip key expansion fills an 11-entry round-key array
// that stays resident until the next key load.
// All vectors are big-endian byte streams: byte 0 occupies bits 0..7, and the
// state is column-major (byte index = row + 4*column).
module inv_cipher #(
  parameter int Nk = 4,   // only 4 (AES-128) is supported
  parameter int Nr = 10   // only 10 is supported
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:Nk*32-1] key,
  input  logic             key_valid_in,
  output logic             key_ready,
  input  logic [0:127]     in,
  input  logic             valid_in,
  output logic             ready,
  output logic [0:127]     out,
  output logic             valid_out
);

  localparam logic [3:0] LAST_ROUND = 4'(Nr);
  localparam logic [7:0] INV_EXP    = 8'hfe;  // a^254 == a^-1 in GF(2^8)

  typedef enum logic [1:0] {NOKEY, KEXP, IDLE, DEC} state_e;

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic [0:127] st_q;
  logic [0:127] out_q;
  logic         valid_out_q;
  logic [0:127] rk_q [0:10];

  logic [3:0]   rk_prev_idx;
  logic [0:127] round_xor;
  logic [0:127] round_mix;
  logic [0:127] rk_next;
  logic         key_fire;

  // ---------------- GF(2^8) helpers (reduction polynomial 0x11B) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = b[i] ? (acc ^ p) : acc;
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse by square-and-multiply; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      r = INV_EXP[i] ? gf_mul(r, a) : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Forward S-box: inverse followed by the affine transform (constant 0x63).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform (constant 0x05) followed by the inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // ---------------- Round transforms on the 128-bit state ----------------
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c - row + 4) % 4)) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
      r[32*c + 8  +: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
      r[32*c + 16 +: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
      r[32*c + 24 +: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
    end
    return r;
  endfunction

  // ---------------- Key schedule ----------------
  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] v;
    case (rc)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Derive round key rc from round key rc-1 (RotWord, SubWord, Rcon on word 0).
  function automatic logic [0:127] next_round_key(input logic [0:127] prev, input logic [7:0] rc_byte);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = prev[0:31];
    w1 = prev[32:63];
    w2 = prev[64:95];
    w3 = prev[96:127];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc_byte, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- Handshakes ----------------
  // Both ready signals are held low while reset is asserted; a pending key load
  // masks block acceptance so the old schedule is never used after a new key.
  assign key_ready = rst_n && ((state_q == NOKEY) || (state_q == IDLE));
  assign ready     = rst_n && (state_q == IDLE) && !key_valid_in;
  assign key_fire  = key_valid_in && key_ready;
  assign out       = out_q;
  assign valid_out = valid_out_q;

  // Round datapath and next key-expansion step, both selected by the round counter.
  always_comb begin
    rk_prev_idx = 4'd0;
    if (rnd_q != 4'd0) begin
      rk_prev_idx = rnd_q - 4'd1;
    end else begin
      rk_prev_idx = 4'd0;
    end
    round_xor = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q[rnd_q];
    round_mix = inv_mix_columns(round_xor);
    rk_next   = next_round_key(rk_q[rk_prev_idx], rcon(rnd_q));
  end

  // Round-key storage; not reset because the FSM refuses blocks until a key is expanded.
  always_ff @(posedge clk) begin
    if (key_fire) begin
      rk_q[0] <= key;
    end else if (rst_n && (state_q == KEXP)) begin
      rk_q[rnd_q] <= rk_next;
    end
  end

  // Control FSM with registered result and one-cycle valid_out pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= NOKEY;
      rnd_q       <= 4'd0;
      st_q        <= {128{1'b0}};
      out_q       <= {128{1'b0}};
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        NOKEY: begin
          if (key_valid_in) begin
            rnd_q   <= 4'd1;
            state_q <= KEXP;
          end
        end
        KEXP: begin
          if (rnd_q == LAST_ROUND) begin
            state_q <= IDLE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        IDLE: begin
          if (key_valid_in) begin
            rnd_q   <= 4'd1;
            state_q <= KEXP;
          end else if (valid_in) begin
            st_q    <= in ^ rk_q[LAST_ROUND];
            rnd_q   <= LAST_ROUND - 4'd1;
            state_q <= DEC;
          end
        end
        DEC: begin
          if (rnd_q == 4'd0) begin
            out_q       <= round_xor;
            valid_out_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            st_q  <= round_mix;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: begin
          state_q <= NOKEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Directed-vector bench for inv_cipher using FIPS-197 and SP800-38A known answers.
module tb_inv_cipher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:127] key;
  logic         key_valid_in;
  logic         key_ready;
  logic [0:127] in;
  logic         valid_in;
  logic         ready;
  logic [0:127] out;
  logic         valid_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] ZERO   = 128'h0;

  localparam logic [0:127] SP_CT [0:3] = '{
    128'h3ad77bb40d7a3660a89ecaf32466ef97,
    128'hf5d3d58503b9699de785895a96fdbaaf,
    128'h43b1cd7f598ece23881b00e3ed030688,
    128'h7b0c785e27e8ad3f8223207104725dd4
  };
  localparam logic [0:127] SP_PT [0:3] = '{
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef,
    128'hf69f2445df4f9b17ad2b417be66c3710
  };

  inv_cipher #(.Nk(4), .Nr(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .key(key), .key_valid_in(key_valid_in), .key_ready(key_ready),
    .in(in), .valid_in(valid_in), .ready(ready),
    .out(out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: load a key and let the 10-cycle expansion finish.
  task automatic load_key(input logic [0:127] k);
    key          = k;
    key_valid_in = 1'b1;
    tick();
    key_valid_in = 1'b0;
    repeat (10) tick();
  endtask

  // Stimulus only: present one block, return result and cycles from accept to valid_out (-1 on timeout).
  task automatic run_block(input logic [0:127] ct, output logic [0:127] pt, output int lat);
    in       = ct;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    lat      = -1;
    pt       = ZERO;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (valid_out) begin
        lat = i;
        pt  = out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; key_valid_in = 1'b0; valid_in = 1'b0; key = ZERO; in = ZERO;
    tick(); tick();
    checks++;
    if (key_ready !== 1'b0) begin failures++; $display("FAIL reset_key_ready_low: got %b expected 0", key_ready); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b expected 0", ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_key_ready_high: got %b expected 1", key_ready); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready_nokey: got %b expected 0", ready); end
    checks++;
    if (out !== ZERO) begin failures++; $display("FAIL reset_out: got %h expected %h", out, ZERO); end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    // Blocks offered without a key are ignored.
    in = CT_C1; valid_in = 1'b1; seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid_out || ready) seen++;
    end
    valid_in = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL nokey_ignore: got %0d activity cycles expected 0", seen); end
  endtask

  task automatic test_fips_c1();
    logic [0:127] pt;
    int lat;
    key = KEY_C1; key_valid_in = 1'b1;
    checks++;
    if (key_ready !== 1'b1) begin failures++; $display("FAIL c1_key_ready: got %b expected 1", key_ready); end
    tick();
    key_valid_in = 1'b0;
    repeat (9) tick();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL c1_kexp_cycle9_ready: got %b expected 0", ready); end
    tick();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL c1_kexp_cycle10_ready: got %b expected 1", ready); end
    run_block(CT_C1, pt, lat);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL c1_latency: got %0d expected 10", lat); end
    checks++;
    if (pt !== PT_C1) begin failures++; $display("FAIL c1_plaintext: got %h expected %h", pt, PT_C1); end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL c1_valid_pulse: got %b expected 0", valid_out); end
    checks++;
    if (out !== PT_C1) begin failures++; $display("FAIL c1_out_hold: got %h expected %h", out, PT_C1); end
  endtask

  task automatic test_back_to_back();
    logic [0:127] pt;
    int lat;
    load_key(KEY_B);
    run_block(CT_B, pt, lat);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 10", lat); end
    checks++;
    if (pt !== PT_B) begin failures++; $display("FAIL b2b_first_plaintext: got %h expected %h", pt, PT_B); end
    // Each following block is offered on the valid_out cycle of its predecessor.
    for (int b = 0; b < 4; b++) begin
      in = SP_CT[b]; valid_in = 1'b1;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", b, ready); end
      tick();
      valid_in = 1'b0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
        tick();
        if (valid_out) begin lat = i; break; end
      end
      checks++;
      if (lat + 1 !== 11) begin failures++; $display("FAIL b2b_gap_%0d: got %0d cycles expected 11", b, lat + 1); end
      checks++;
      if (out !== SP_PT[b]) begin failures++; $display("FAIL b2b_plaintext_%0d: got %h expected %h", b, out, SP_PT[b]); end
    end
  endtask

  task automatic test_zero_key_hold();
    int seen;
    key = ZERO; key_valid_in = 1'b1; in = CT_Z; valid_in = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL hold_key_priority_ready: got %b expected 0", ready); end
    tick();
    key_valid_in = 1'b0;
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (ready || valid_out) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL hold_kexp_ready: got %0d busy-violations expected 0", seen); end
    tick();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL hold_idle_ready: got %b expected 1", ready); end
    tick();
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (ready || valid_out) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL hold_dec_ready: got %0d busy-violations expected 0", seen); end
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin failures++; $display("FAIL hold_result_valid: got %b expected 1", valid_out); end
    checks++;
    if (out !== ZERO) begin failures++; $display("FAIL hold_plaintext: got %h expected %h", out, ZERO); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid_out) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL hold_extra_results: got %0d expected 0", seen); end
  endtask

  task automatic test_key_priority();
    logic [0:127] pt;
    int lat;
    int seen;
    key = KEY_C1; key_valid_in = 1'b1; in = CT_C1; valid_in = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL prio_ready: got %b expected 0", ready); end
    tick();
    key_valid_in = 1'b0; valid_in = 1'b0;
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (valid_out) seen++;
    end
    checks++;
    if (key_ready !== 1'b0) begin failures++; $display("FAIL prio_kexp_key_ready: got %b expected 0", key_ready); end
    tick();
    if (valid_out) seen++;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL prio_kexp_len: got ready=%b expected 1", ready); end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL prio_block_accepted: got %0d results expected 0", seen); end
    run_block(CT_C1, pt, lat);
    checks++;
    if (pt !== PT_C1) begin failures++; $display("FAIL prio_new_key: got %h expected %h", pt, PT_C1); end
  endtask

  task automatic test_key_ignore();
    logic [0:127] pt;
    int lat;
    int seen;
    in = CT_C1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    key = KEY_B; key_valid_in = 1'b1;
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (key_ready) seen++;
    end
    key_valid_in = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL ignore_key_ready: got %0d cycles high expected 0", seen); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || out !== PT_C1) begin failures++; $display("FAIL ignore_inflight: got %b/%h expected 1/%h", valid_out, out, PT_C1); end
    run_block(CT_C1, pt, lat);
    checks++;
    if (pt !== PT_C1) begin failures++; $display("FAIL ignore_key_kept: got %h expected %h", pt, PT_C1); end
  endtask

  task automatic test_reset_mid_dec();
    logic [0:127] pt;
    int lat;
    int seen;
    in = CT_C1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || key_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b/%b expected 0/0", ready, key_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out !== ZERO || valid_out !== 1'b0) begin failures++; $display("FAIL midrst_out: got %h/%b expected %h/0", out, valid_out, ZERO); end
    checks++;
    if (key_ready !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL midrst_nokey: got %b/%b expected 1/0", key_ready, ready); end
    in = CT_C1; valid_in = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_out || ready) seen++;
    end
    valid_in = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midrst_no_result: got %0d activity cycles expected 0", seen); end
    load_key(KEY_C1);
    run_block(CT_C1, pt, lat);
    checks++;
    if (lat !== 10 || pt !== PT_C1) begin failures++; $display("FAIL midrst_reload: got lat=%0d %h expected lat=10 %h", lat, pt, PT_C1); end
  endtask

  initial begin
    rst_n = 1'b0; key_valid_in = 1'b0; valid_in = 1'b0; key = ZERO; in = ZERO;
    test_reset();
    test_fips_c1();
    test_back_to_back();
    test_zero_key_hold();
    test_key_priority();
    test_key_ignore();
    test_reset_mid_dec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
